// File: rtl/quad_pkg.sv
// quad_pkg: shared state type, Gray position codes and transition decoder for quad_decoder.
package quad_pkg;
  typedef enum logic {INIT, RUN} quad_state_t;
  localparam logic [1:0] POS0 = 2'b00;
  localparam logic [1:0] POS1 = 2'b10;
  localparam logic [1:0] POS2 = 2'b11;
  localparam logic [1:0] POS3 = 2'b01;
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return ab == POS0 ? 2'd0 : ab == POS1 ? 2'd1 : ab == POS2 ? 2'd2 : 2'd3;
  endfunction
  // Returns {step, up, err}; position delta 1 is forward, 3 reverse, 2 is a double change.
  function automatic logic [2:0] decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    return {d[0], d == 2'd1, d == 2'd2};
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder inputs, controls and decoded outputs of quad_decoder.
interface quad_decoder_if #(parameter int ERR_W = 8);
  logic a;
  logic b;
  logic enable;
  logic clr_err;
  logic step;
  logic up;
  logic err;
  logic [ERR_W-1:0] err_count;
  logic [1:0] ab_filt;
  modport master (output a, b, enable, clr_err, input step, up, err, err_count, ab_filt);
  modport slave (input a, b, enable, clr_err, output step, up, err, err_count, ab_filt);
endinterface

// File: rtl/quad_filter.sv
// quad_filter: one channel's synchronizer plus persistence filter.
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILT_N + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  logic last;
  assign s = sync[SYNC_STAGES-1];
  assign last = cnt == CW'(FILT_N - 1);
  // Accept on the edge that completes FILT_N consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      cnt <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      cnt <= (s == dout || last) ? '0 : cnt + 1'b1;
      dout <= (s != dout && last) ? s : dout;
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: filtered x4 quadrature decoder with step/dir pulses and saturating error count.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_N = 4,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst,
  quad_decoder_if.slave bus
);
  localparam int INIT_LAST = SYNC_STAGES + FILT_N;
  localparam int IW = $clog2(INIT_LAST + 1);
  quad_state_t state, state_n;
  logic [IW-1:0] init_cnt, init_n;
  logic [1:0] ab_filt, prev_ab, prev_n;
  logic [2:0] dec;
  logic step, step_n, up, up_n, err, err_n, done, run_ok;
  logic [ERR_W-1:0] err_count, cnt_n;
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_N(FILT_N)) u_fa (
    .clk(clk), .rst(rst), .din(bus.a), .dout(ab_filt[1])
  );
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_N(FILT_N)) u_fb (
    .clk(clk), .rst(rst), .din(bus.b), .dout(ab_filt[0])
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      init_cnt <= '0;
      prev_ab <= '0;
      step <= 1'b0;
      up <= 1'b1;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      init_cnt <= init_n;
      prev_ab <= prev_n;
      step <= step_n;
      up <= up_n;
      err <= err_n;
      err_count <= cnt_n;
    end
  end
  // INIT waits for the filters to settle so a resting non-00 position is not seen as motion.
  always_comb begin
    dec = decode(prev_ab, ab_filt);
    done = init_cnt == IW'(INIT_LAST);
    run_ok = state == RUN && bus.enable;
    state_n = (state == INIT && done) ? RUN : state;
    init_n = (state == INIT && !done) ? init_cnt + 1'b1 : init_cnt;
    prev_n = (state == RUN || done) ? ab_filt : prev_ab;
    step_n = run_ok & dec[2];
    err_n = run_ok & dec[0];
    up_n = step_n ? dec[1] : up;
    cnt_n = bus.clr_err ? '0 : (err && !(&err_count)) ? err_count + 1'b1 : err_count;
  end
  assign bus.step = step;
  assign bus.up = up;
  assign bus.err = err;
  assign bus.err_count = err_count;
  assign bus.ab_filt = ab_filt;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed vector table plus hand sequences for quad_decoder.
module tb_quad_decoder;
  import quad_pkg::*;
  typedef struct {
    logic a;
    logic b;
    int hold;
    int steps;
    logic up;
    int errs;
    logic [1:0] ab;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int steps;
  int errs;
  int lat;
  bit found;
  vec_t vecs[9];
  always #5 clk = ~clk;
  quad_decoder_if #(.ERR_W(8)) bus ();
  quad_decoder #(.SYNC_STAGES(2), .FILT_N(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      steps += int'(bus.step);
      errs += int'(bus.err);
    end
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 10, 1, 1'b1, 0, 2'b10};
    vecs[1] = '{1'b1, 1'b1, 10, 1, 1'b1, 0, 2'b11};
    vecs[2] = '{1'b0, 1'b1, 10, 1, 1'b1, 0, 2'b01};
    vecs[3] = '{1'b0, 1'b0, 10, 1, 1'b1, 0, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 10, 1, 1'b0, 0, 2'b01};
    vecs[5] = '{1'b1, 1'b1, 10, 1, 1'b0, 0, 2'b11};
    vecs[6] = '{1'b1, 1'b0, 10, 1, 1'b0, 0, 2'b10};
    vecs[7] = '{1'b0, 1'b0, 10, 1, 1'b0, 0, 2'b00};
    vecs[8] = '{1'b0, 1'b0, 10, 0, 1'b0, 0, 2'b00};
    bus.a = 1'b1;
    bus.b = 1'b1;
    bus.enable = 1'b1;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_up", int'(bus.up), 1);
    chk("rst_errcnt", int'(bus.err_count), 0);
    chk("rst_ab", int'(bus.ab_filt), 0);
    rst = 1'b1;
    steps = 0; errs = 0;
    run(30);
    chk("init_steps", steps, 0);
    chk("init_errs", errs, 0);
    chk("init_ab", int'(bus.ab_filt), 3);
    chk("init_run", int'(dut.state == RUN), 1);
    bus.a = 1'b0; bus.b = 1'b0;
    steps = 0; errs = 0;
    run(10);
    chk("ill11_steps", steps, 0);
    chk("ill11_errs", errs, 1);
    chk("ill11_errcnt", int'(bus.err_count), 1);
    chk("ill11_up", int'(bus.up), 1);
    bus.clr_err = 1'b1; run(1); bus.clr_err = 1'b0;
    chk("clr_errcnt", int'(bus.err_count), 0);
    bus.a = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.step) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 7);
    chk("lat_up", int'(bus.up), 1);
    run(10);
    bus.a = 1'b0;
    run(12);
    chk("lat_back_up", int'(bus.up), 0);
    for (int i = 0; i < 9; i++) begin
      bus.a = vecs[i].a;
      bus.b = vecs[i].b;
      steps = 0; errs = 0;
      run(vecs[i].hold);
      chk($sformatf("vec%0d_steps", i), steps, vecs[i].steps);
      chk($sformatf("vec%0d_up", i), int'(bus.up), int'(vecs[i].up));
      chk($sformatf("vec%0d_errs", i), errs, vecs[i].errs);
      chk($sformatf("vec%0d_ab", i), int'(bus.ab_filt), int'(vecs[i].ab));
    end
    steps = 0;
    bus.a = 1'b1; run(3); bus.a = 1'b0; run(10);
    chk("glitch3_steps", steps, 0);
    chk("glitch3_ab", int'(bus.ab_filt), 0);
    steps = 0;
    bus.a = 1'b1; run(4); bus.a = 1'b0; run(5);
    chk("glitch4_steps", steps, 1);
    chk("glitch4_up", int'(bus.up), 1);
    steps = 0;
    run(10);
    chk("glitch4_back_steps", steps, 1);
    chk("glitch4_back_up", int'(bus.up), 0);
    steps = 0; errs = 0;
    bus.a = 1'b1; bus.b = 1'b1;
    run(10);
    chk("ill00_steps", steps, 0);
    chk("ill00_errs", errs, 1);
    chk("ill00_errcnt", int'(bus.err_count), 1);
    bus.clr_err = 1'b1; run(1); bus.clr_err = 1'b0;
    chk("clr2_errcnt", int'(bus.err_count), 0);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      bus.a = ~bus.a;
      bus.b = ~bus.b;
      run(7);
    end
    run(10);
    chk("sat_errs", errs, 300);
    chk("sat_errcnt", int'(bus.err_count), 255);
    bus.a = 1'b0; bus.b = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.err) begin
        found = 1;
        break;
      end
    end
    chk("coinc_err_seen", int'(found), 1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    run(3);
    chk("coinc_errcnt", int'(bus.err_count), 0);
    bus.enable = 1'b0;
    steps = 0; errs = 0;
    bus.a = 1'b1; bus.b = 1'b0; run(10);
    bus.a = 1'b1; bus.b = 1'b1; run(10);
    bus.a = 1'b0; bus.b = 1'b1; run(10);
    bus.a = 1'b1; bus.b = 1'b0; run(10);
    chk("dis_steps", steps, 0);
    chk("dis_errs", errs, 0);
    chk("dis_up", int'(bus.up), 0);
    chk("dis_errcnt", int'(bus.err_count), 0);
    bus.enable = 1'b1;
    steps = 0; errs = 0;
    run(10);
    chk("reen_burst", steps + errs, 0);
    bus.a = 1'b1; bus.b = 1'b1;
    run(10);
    chk("reen_steps", steps, 1);
    chk("reen_up", int'(bus.up), 1);
    chk("reen_errcnt", int'(bus.err_count), 0);
    bus.a = 1'b0; bus.b = 1'b0;
    run(10);
    chk("pre_rst_errcnt", int'(bus.err_count), 1);
    bus.b = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.step) begin
        found = 1;
        break;
      end
    end
    chk("pre_rst_step_seen", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_step", int'(bus.step), 0);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_up", int'(bus.up), 1);
    chk("arst_errcnt", int'(bus.err_count), 0);
    chk("arst_ab", int'(bus.ab_filt), 0);
    chk("arst_init", int'(dut.state == INIT), 1);
    @(negedge clk);
    rst = 1'b1;
    run(2);
    chk("rel_init", int'(dut.state == INIT), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Quadrature (A/B) incremental-encoder decoder. Synchronizes and glitch-filters two raw encoder channels and decodes x4 Gray transitions. It emits one-cycle step pulses with a direction flag, intended to drive the enable/direction inputs of the team's up/down position counter. It also flags and counts illegal double transitions.

Parameters:
SYNC_STAGES, 2, flops per channel in the input synchronizer (legal range ≥2).
FILT_N, 4, consecutive cycles a new synchronized level must persist before it is accepted (legal range ≥1).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
a  input  1  raw encoder channel A (asynchronous)
b  input  1  raw encoder channel B (asynchronous)
enable  input  1  decode enable; when 0, step and err are suppressed
clr_err  input  1  synchronous clear of err_count
step  output  1  one-cycle pulse per valid quadrature transition
up  output  1  direction of the most recent valid step (1 = forward)
err  output  1  one-cycle pulse on an illegal transition (both channels change)
err_count  output  ERR_W  saturating count of err events
ab_filt  output  2  filtered levels {A,B}

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer and filter flops = 0. step=0, err=0, up=1, err_count=0, ab_filt=00. FSM enters INIT.
- Synchronizer: SYNC_STAGES flops per channel, no logic between stages.
- Filter, per channel: filt counter increments while the synchronized level ≠ the filtered level, and clears when they are equal. When the counter has seen FILT_N consecutive differing cycles, the filtered level takes the synchronized value and the counter clears. Any intervening equal cycle restarts the count.
- FSM states:
  - INIT: counts SYNC_STAGES+FILT_N+1 cycles after reset release, then loads prev_ab ← ab_filt and goes to RUN. It emits no step and no err. This suppresses a spurious event when the encoder rests at a non-00 position.
  - RUN: compare ab_filt with prev_ab every cycle. prev_ab ← ab_filt every cycle.
- Decode in RUN, with outputs registered (valid the cycle after ab_filt changes):
  - Forward sequence 00→10→11→01→00 (A leads): step=1, up=1.
  - Reverse sequence 00→01→11→10→00: step=1, up=0.
  - Both bits change in one cycle: err=1, step=0, up unchanged. prev_ab still updates to the new value.
  - No change: step=0, err=0, up holds.
- Latency: raw edge sampled at edge 0 → ab_filt changes after edge SYNC_STAGES+FILT_N → step/err high for exactly one cycle after edge SYNC_STAGES+FILT_N+1. With defaults this is 7 cycles.
- enable=0: step and err are forced 0, up holds, and err_count does not increment. prev_ab keeps tracking, so re-enabling produces no burst or catch-up steps.
- err_count: increments on each err pulse and saturates at 2^ERR_W−1. If clr_err and err occur in the same cycle, clr_err wins and the result is 0.
- Filtered channels can change at most once per FILT_N cycles each. Input edges faster than this are filtered out, not counted.
- Reset mid-operation: all outputs go to their reset values immediately and the FSM returns to INIT.

Decomposition:
- Package quad_pkg holds:
  - typedef enum {INIT, RUN} quad_state_t
  - 2-bit Gray position constants
  - a function decode(prev, cur) returning {step, up, err}
- Sub-module quad_filter (parameters SYNC_STAGES, FILT_N; ports clk, rst, din, dout) contains one channel's synchronizer and filter. It is instantiated twice.

Test Plan:
- Hold a=b=1 through reset, release, run 30 cycles → step never 1, err never 1, ab_filt=11, FSM in RUN.
- Forward sequence 00→10→11→01→00, each level held 10 cycles → exactly 4 step pulses, up=1, each pulse 7 cycles after the raw edge.
- Reverse sequence 00→01→11→10→00 → 4 step pulses with up=0. After that, up stays 0 while step=0.
- Glitch: a=1 for 3 cycles then back to 0 (FILT_N=4) → no step, ab_filt stays 00. Held for 4 cycles → one step, up=1.
- Raw 00→11 simultaneously → one err pulse, no step, err_count=1. Apply clr_err → 0. Drive 300 illegal transitions → err_count=255. clr_err coincident with err → 0.
- enable=0 across 3 forward steps → no step or err. Raise enable → next forward edge gives exactly one step.
- Assert rst mid-sequence → step/err/err_count go to 0 and up to 1 asynchronously.
